// File: rtl/conv_13_sdiv_pkg.sv
// Shared constants and types for the conv_13 signed sequential divider.
// Dividend is a 24-bit product-domain value, divisor an 8-bit weight,
// quotient saturates to 16 bits, and the remainder is 8 bits.
package conv_13_sdiv_pkg;

  localparam int unsigned DVD_W = 24;  // dividend width
  localparam int unsigned DVS_W = 8;   // divisor width
  localparam int unsigned QUO_W = 16;  // quotient (dout) width
  localparam int unsigned REM_W = 8;   // remainder width
  localparam int unsigned ITERS = 24;  // restoring iterations, one per dividend bit
  localparam int unsigned CNT_W = 5;   // iteration counter width

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  localparam logic [QUO_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [QUO_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/conv_13_sdiv_seq_if.sv
// Handshake and data bundle for conv_13_sdiv_seq.
//   master: drives ap_start/din0/din1, observes status and results
//   slave : the divider itself
interface conv_13_sdiv_seq_if
  import conv_13_sdiv_pkg::*;
();

  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_idle;
  logic [DVD_W-1:0] din0;
  logic [DVS_W-1:0] din1;
  logic [QUO_W-1:0] dout;
  logic [REM_W-1:0] rem;
  logic             ovf;
  logic             dbz;

  modport master (
    output ap_start, din0, din1,
    input  ap_ready, ap_done, ap_idle, dout, rem, ovf, dbz
  );

  modport slave (
    input  ap_start, din0, din1,
    output ap_ready, ap_done, ap_idle, dout, rem, ovf, dbz
  );

endinterface

// File: rtl/conv_13_udiv_step.sv
// One combinational restoring-division iteration on magnitudes.
//   i_prem : partial remainder (always < i_dmag for a non-zero divisor)
//   i_bit  : next dividend bit, MSB first
//   i_dmag : divisor magnitude
//   o_rem  : next partial remainder
//   o_q    : quotient bit produced this iteration
module conv_13_udiv_step
  import conv_13_sdiv_pkg::*;
(
  input  logic [REM_W-1:0] i_prem,
  input  logic             i_bit,
  input  logic [DVS_W-1:0] i_dmag,
  output logic [REM_W-1:0] o_rem,
  output logic             o_q
);

  logic [REM_W:0] w_trial;

  // The true difference is below 256, so subtracting in 8 bits is exact.
  always_comb begin
    w_trial = {i_prem, i_bit};
    o_q     = (w_trial >= {1'b0, i_dmag});
    o_rem   = o_q ? (w_trial[REM_W-1:0] - i_dmag) : w_trial[REM_W-1:0];
  end

endmodule

// File: rtl/conv_13_sdiv_seq.sv
// Fixed-latency signed divider: 24-bit dividend / 8-bit divisor.
//   ap_clk, ap_rst : clock and synchronous active-high reset
//   bus (slave)    : ap_start/ap_ready/ap_done/ap_idle handshake,
//                    din0/din1 operands, dout/rem/ovf/dbz results
// Capture at T, 24 CALC cycles, sign/saturation fix at T+25, ap_done at T+26.
module conv_13_sdiv_seq
  import conv_13_sdiv_pkg::*;
#(
  parameter logic [31:0] ID        = 32'd1,
  parameter logic [31:0] NUM_STAGE = 32'd26
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  conv_13_sdiv_seq_if.slave      bus
);

  localparam logic [DVD_W-1:0] Q_POS_LIM = DVD_W'(SAT_MAX);
  localparam logic [DVD_W-1:0] Q_NEG_LIM = DVD_W'(-SAT_MIN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ITERS - 1);

  state_t           r_state, w_next;
  logic [DVD_W-1:0] r_dvd;     // dividend magnitude, shifts into quotient
  logic [REM_W-1:0] r_prem;
  logic [DVS_W-1:0] r_dmag;
  logic             r_sgn_n, r_sgn_d;
  logic [CNT_W-1:0] r_cnt;
  logic [QUO_W-1:0] r_dout;
  logic [REM_W-1:0] r_rem;
  logic             r_ovf, r_dbz;

  logic             w_idle, w_ready, w_done, w_last, w_neg;
  logic [REM_W-1:0] w_step_rem;
  logic             w_step_q;
  logic [QUO_W-1:0] w_fix_dout;
  logic [REM_W-1:0] w_fix_rem;
  logic             w_fix_ovf, w_fix_dbz;

  conv_13_udiv_step u_step (
    .i_prem (r_prem),
    .i_bit  (r_dvd[DVD_W-1]),
    .i_dmag (r_dmag),
    .o_rem  (w_step_rem),
    .o_q    (w_step_q)
  );

  assign w_last = (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.ap_start) w_next = ST_CALC;
      ST_CALC: if (w_last)       w_next = ST_FIX;
      ST_FIX:                    w_next = ST_DONE;
      ST_DONE:                   w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    w_idle  = (r_state == ST_IDLE);
    w_ready = w_idle & bus.ap_start & ~ap_rst;
    w_done  = (r_state == ST_DONE);
  end

  // Sign application and saturation on the finished magnitudes
  always_comb begin
    w_neg      = r_sgn_n ^ r_sgn_d;
    w_fix_dbz  = (r_dmag == '0);
    w_fix_ovf  = 1'b0;
    w_fix_dout = w_neg ? -r_dvd[QUO_W-1:0] : r_dvd[QUO_W-1:0];
    w_fix_rem  = r_sgn_n ? -r_prem : r_prem;
    if (w_fix_dbz) begin
      w_fix_ovf  = 1'b1;
      w_fix_rem  = '0;
      w_fix_dout = r_sgn_n ? SAT_NEG : SAT_POS;
    end else if (!w_neg && (r_dvd > Q_POS_LIM)) begin
      w_fix_ovf  = 1'b1;
      w_fix_dout = SAT_POS;
    end else if (w_neg && (r_dvd > Q_NEG_LIM)) begin
      w_fix_ovf  = 1'b1;
      w_fix_dout = SAT_NEG;
    end
  end

  // Datapath registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_dvd   <= '0;
      r_prem  <= '0;
      r_dmag  <= '0;
      r_sgn_n <= 1'b0;
      r_sgn_d <= 1'b0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (bus.ap_start) begin
          // -(-2^23) stays 24'h800000 as an unsigned magnitude
          r_dvd   <= bus.din0[DVD_W-1] ? -bus.din0 : bus.din0;
          r_dmag  <= bus.din1[DVS_W-1] ? -bus.din1 : bus.din1;
          r_sgn_n <= bus.din0[DVD_W-1];
          r_sgn_d <= bus.din1[DVS_W-1];
          r_prem  <= '0;
          r_cnt   <= '0;
        end
        ST_CALC: begin
          r_dvd  <= {r_dvd[DVD_W-2:0], w_step_q};
          r_prem <= w_step_rem;
          r_cnt  <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          r_dout <= w_fix_dout;
          r_rem  <= w_fix_rem;
          r_ovf  <= w_fix_ovf;
          r_dbz  <= w_fix_dbz;
          r_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ap_idle  = w_idle;
  assign bus.ap_ready = w_ready;
  assign bus.ap_done  = w_done;
  assign bus.dout     = r_dout;
  assign bus.rem      = r_rem;
  assign bus.ovf      = r_ovf;
  assign bus.dbz      = r_dbz;

endmodule

// File: tb/tb_conv_13_sdiv_seq.sv
// Self-checking bench for conv_13_sdiv_seq: expected results are computed by
// an integer reference model when a division is started, queued, and compared
// when ap_done is observed (including the cycle it arrives in).
module tb_conv_13_sdiv_seq;
  import conv_13_sdiv_pkg::*;

  typedef struct {
    logic [15:0] dout;
    logic [7:0]  rem;
    logic        ovf;
    logic        dbz;
    int          done_cyc;
    int          a;
    int          b;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  conv_13_sdiv_seq_if bus ();

  conv_13_sdiv_seq #(
    .ID        (32'd1),
    .NUM_STAGE (32'd26)
  ) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int a, input int b, input int done_cyc);
    exp_t e;
    int   q, r;
    e.a = a; e.b = b; e.done_cyc = done_cyc;
    e.ovf = 1'b0; e.dbz = 1'b0;
    if (b == 0) begin
      e.dbz  = 1'b1;
      e.ovf  = 1'b1;
      e.rem  = 8'h00;
      e.dout = (a < 0) ? 16'h8000 : 16'h7FFF;
    end else begin
      q = a / b;   // truncates toward zero
      r = a % b;   // sign follows the dividend
      e.rem = 8'(r);
      if (q > 32767) begin
        e.dout = 16'h7FFF; e.ovf = 1'b1;
      end else if (q < -32768) begin
        e.dout = 16'h8000; e.ovf = 1'b1;
      end else begin
        e.dout = 16'(q);
      end
    end
    return e;
  endfunction

  // Result monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && bus.ap_done === 1'b1) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexpected: ap_done=1 at cycle %0d, required 0 (nothing pending)", cyc);
        end else begin
          mon_e = sb.pop_front();
          tests++;
          if (cyc !== mon_e.done_cyc) begin
            fails++;
            $display("FAIL done_cycle(%0d/%0d): got cycle %0d, required %0d", mon_e.a, mon_e.b, cyc, mon_e.done_cyc);
          end
          tests++;
          if (bus.dout !== mon_e.dout) begin
            fails++;
            $display("FAIL dout(%0d/%0d): got %h, required %h", mon_e.a, mon_e.b, bus.dout, mon_e.dout);
          end
          tests++;
          if (bus.rem !== mon_e.rem) begin
            fails++;
            $display("FAIL rem(%0d/%0d): got %h, required %h", mon_e.a, mon_e.b, bus.rem, mon_e.rem);
          end
          tests++;
          if (bus.ovf !== mon_e.ovf) begin
            fails++;
            $display("FAIL ovf(%0d/%0d): got %b, required %b", mon_e.a, mon_e.b, bus.ovf, mon_e.ovf);
          end
          tests++;
          if (bus.dbz !== mon_e.dbz) begin
            fails++;
            $display("FAIL dbz(%0d/%0d): got %b, required %b", mon_e.a, mon_e.b, bus.dbz, mon_e.dbz);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, %0d results outstanding", sb.size());
    $fatal(1, "timeout");
  end

  // Starts a division from IDLE; operands are scrambled right after capture.
  task automatic do_div(input int a, input int b, input bit push);
    @(negedge clk);
    bus.ap_start = 1'b1;
    bus.din0 = 24'(a);
    bus.din1 = 8'(b);
    #1;
    tests++;
    if (bus.ap_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_at_start(%0d/%0d): got %b, required 1", a, b, bus.ap_ready);
    end
    if (push) sb.push_back(model(a, b, cyc + 26));
    @(negedge clk);
    bus.ap_start = 1'b0;
    bus.din0 = 24'($urandom);
    bus.din1 = 8'($urandom);
    #1;
    tests++;
    if (bus.ap_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_capture(%0d/%0d): got %b, required 0", a, b, bus.ap_ready);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d results outstanding after %0d cycles, required 0", sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic [31:0] got [7];
    logic [31:0] want[7];
    string       nm  [7];
    rst = 1'b1;
    bus.ap_start = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;
    repeat (3) @(negedge clk);
    #1;
    got[0] = 32'(bus.dout);     want[0] = 0; nm[0] = "rst_dout";
    got[1] = 32'(bus.rem);      want[1] = 0; nm[1] = "rst_rem";
    got[2] = 32'(bus.ovf);      want[2] = 0; nm[2] = "rst_ovf";
    got[3] = 32'(bus.dbz);      want[3] = 0; nm[3] = "rst_dbz";
    got[4] = 32'(bus.ap_done);  want[4] = 0; nm[4] = "rst_done";
    got[5] = 32'(bus.ap_ready); want[5] = 0; nm[5] = "rst_ready";
    got[6] = 32'(bus.ap_idle);  want[6] = 1; nm[6] = "rst_idle";
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (got[i] !== want[i]) begin
        fails++;
        $display("FAIL %s: got %0d, required %0d", nm[i], got[i], want[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_div(1000000, 100, 1'b1);
    wait_drain(40);
  endtask

  task automatic test_signs();
    int av[6] = '{-7, 7, -128, 300, -1000, 127};
    int bv[6] = '{2, -2, -128, -7, 3, 127};
    for (int i = 0; i < 6; i++) begin
      do_div(av[i], bv[i], 1'b1);
      wait_drain(40);
    end
  endtask

  task automatic test_saturation();
    int av[7] = '{8388607, -8388608, -8388608, 32767, -32768, 32768, -32769};
    int bv[7] = '{1, -1, 127, 1, 1, -1, 1};
    for (int i = 0; i < 7; i++) begin
      do_div(av[i], bv[i], 1'b1);
      wait_drain(40);
    end
  endtask

  task automatic test_dbz();
    int av[3] = '{-5, 5, 0};
    for (int i = 0; i < 3; i++) begin
      do_div(av[i], 0, 1'b1);
      wait_drain(40);
    end
  endtask

  task automatic test_ignore_start();
    do_div(-777777, 33, 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      bus.ap_start = 1'b1;
      bus.din0 = 24'($urandom);
      bus.din1 = 8'($urandom);
      #1;
      tests++;
      if (bus.ap_ready !== 1'b0) begin
        fails++;
        $display("FAIL ready_while_busy: got %b at cycle %0d, required 0", bus.ap_ready, cyc);
      end
      @(negedge clk);
    end
    bus.ap_start = 1'b0;
    wait_drain(40);
  endtask

  task automatic test_mid_reset();
    logic [31:0] got [7];
    logic [31:0] want[7];
    string       nm  [7];
    int          t0;
    do_div(1000000, 100, 1'b0);
    t0 = cyc - 1;
    while (cyc < t0 + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    got[0] = 32'(bus.dout);     want[0] = 0; nm[0] = "midrst_dout";
    got[1] = 32'(bus.rem);      want[1] = 0; nm[1] = "midrst_rem";
    got[2] = 32'(bus.ovf);      want[2] = 0; nm[2] = "midrst_ovf";
    got[3] = 32'(bus.dbz);      want[3] = 0; nm[3] = "midrst_dbz";
    got[4] = 32'(bus.ap_done);  want[4] = 0; nm[4] = "midrst_done";
    got[5] = 32'(bus.ap_ready); want[5] = 0; nm[5] = "midrst_ready";
    got[6] = 32'(bus.ap_idle);  want[6] = 1; nm[6] = "midrst_idle";
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (got[i] !== want[i]) begin
        fails++;
        $display("FAIL %s: got %0d, required %0d", nm[i], got[i], want[i]);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // An unaborted first division would raise ap_done early and be caught.
    do_div(300, 7, 1'b1);
    wait_drain(60);
  endtask

  task automatic test_back_to_back();
    int t0 = 0;
    int ncap = 0;
    int a;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      a = (i % 2 == 1) ? -(i * 5003 + 17) : (i * 7919 + 3);
      bus.ap_start = 1'b1;
      bus.din0 = 24'(a);
      bus.din1 = 8'(-9);
      #1;
      if (i == 0) t0 = cyc;
      if (bus.ap_ready === 1'b1) begin
        tests++;
        if (cyc !== t0 + 27 * ncap) begin
          fails++;
          $display("FAIL b2b_capture_cycle: got cycle %0d, required %0d", cyc, t0 + 27 * ncap);
        end
        sb.push_back(model(a, -9, cyc + 26));
        ncap++;
      end
    end
    bus.ap_start = 1'b0;
    // 60 held cycles span captures at T, T+27 and T+54.
    tests++;
    if (ncap !== 3) begin
      fails++;
      $display("FAIL b2b_capture_count: got %0d, required 3", ncap);
    end
    wait_drain(80);
  endtask

  task automatic test_random();
    int a, b;
    for (int i = 0; i < 20; i++) begin
      a = int'($signed(24'($urandom)));
      if (i % 3 == 0) a = a >>> 10;
      b = int'($signed(8'($urandom)));
      do_div(a, b, 1'b1);
      wait_drain(40);
    end
  endtask

  initial begin : main
    bus.ap_start = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;
    test_reset();
    test_basic();
    test_signs();
    test_saturation();
    test_dbz();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
